// File: rtl/left_rot_pkg.sv
// Shared definitions for the multi-cycle left rotator.
//   - state_e  : controller states (idle, shifting, result held)
//   - OP_ROL / OP_SLL : operation encodings, used when LEFT_ROTATOR_SHIFT_OP_EN is defined
//   - DEF_WIDTH / DEF_CNT_W : default operand and count widths
package left_rot_pkg;

  parameter int unsigned DEF_WIDTH = 16;
  parameter int unsigned DEF_CNT_W = 4;

  localparam logic OP_ROL = 1'b0;
  localparam logic OP_SLL = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/left_rotator_seq_if.sv
// Handshake/data bundle for left_rotator_seq.
//   in_valid/in_ready/In/Cnt[/Op]   : operand request channel
//   out_valid/out_ready/Out         : result channel
//   busy                            : high while an operation is in flight or its result is held
// Op exists only when LEFT_ROTATOR_SHIFT_OP_EN is defined.
// master = requester/consumer side, slave = the rotator.
interface left_rotator_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] In;
  logic [CNT_W-1:0] Cnt;
`ifdef LEFT_ROTATOR_SHIFT_OP_EN
  logic             Op;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             busy;

`ifdef LEFT_ROTATOR_SHIFT_OP_EN
  modport master (
    output in_valid, In, Cnt, Op, out_ready,
    input  in_ready, out_valid, Out, busy
  );

  modport slave (
    input  in_valid, In, Cnt, Op, out_ready,
    output in_ready, out_valid, Out, busy
  );
`else
  modport master (
    output in_valid, In, Cnt, out_ready,
    input  in_ready, out_valid, Out, busy
  );

  modport slave (
    input  in_valid, In, Cnt, out_ready,
    output in_ready, out_valid, Out, busy
  );
`endif

endinterface

// File: rtl/left_rot_stage.sv
// One log-shifter stage: conditionally rotates (or logically shifts) data left by 2^stage.
//   data      : operand
//   en        : apply this stage; otherwise data passes through unchanged
//   stage     : stage index, shift amount is 1 << stage (must stay below WIDTH)
//   zero_fill : 1 = logical shift left (low 2^stage bits become 0), 0 = rotate left
//   result    : stage output
module left_rot_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STG_W = 2
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [STG_W-1:0] stage,
  input  logic             zero_fill,
  output logic [WIDTH-1:0] result
);

  int unsigned      amt;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] rol;

  always_comb begin
    amt = 32'd1 << stage;
    shl = data << amt;
    // Bits pushed out the top wrap into the bottom for a rotate.
    rol = shl | (data >> (WIDTH - amt));
    if (!en) begin
      result = data;
    end else if (zero_fill) begin
      result = shl;
    end else begin
      result = rol;
    end
  end

endmodule

// File: rtl/left_rotator_seq.sv
// Multi-cycle left rotator: one log-shifter stage per clock (by 1, 2, 4, ... bits), so a
// CNT_W-bit count takes CNT_W shift cycles. Valid/ready handshake on both sides.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : left_rotator_seq_if.slave (in_valid/in_ready/In/Cnt[/Op], out_valid/out_ready/Out,
//           busy)
// Optional build macro LEFT_ROTATOR_SHIFT_OP_EN adds the Op input: Op=1 selects logical shift
// left instead of rotate. Without it the block always rotates; latency is identical.
module left_rotator_seq
  import left_rot_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst_n,
  left_rotator_seq_if.slave bus
);

  localparam int unsigned StgW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [StgW-1:0] LastStage = StgW'(CNT_W - 1);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] cnt_q;
  logic [StgW-1:0]  stage_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             zero_fill;
  logic [WIDTH-1:0] stage_res;

`ifdef LEFT_ROTATOR_SHIFT_OP_EN
  logic op_q;
  assign zero_fill = (op_q == OP_SLL);
`else
  assign zero_fill = 1'b0;
`endif

  // Single stage shared across cycles; stage_q selects the shift distance.
  left_rot_stage #(
    .WIDTH(WIDTH),
    .STG_W(StgW)
  ) u_stage (
    .data     (data_q),
    .en       (cnt_q[stage_q]),
    .stage    (stage_q),
    .zero_fill(zero_fill),
    .result   (stage_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      data_q      <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      stage_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef LEFT_ROTATOR_SHIFT_OP_EN
      op_q        <= OP_ROL;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            data_q     <= bus.In;
            cnt_q      <= bus.Cnt;
            stage_q    <= '0;
`ifdef LEFT_ROTATOR_SHIFT_OP_EN
            op_q       <= bus.Op;
`endif
            state_q    <= StShift;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StShift: begin
          data_q  <= stage_res;
          stage_q <= stage_q + StgW'(1);
          // Count of zero still walks every stage so latency never depends on Cnt.
          if (stage_q == LastStage) begin
            out_q       <= stage_res;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // Out is deliberately left as-is after the handshake.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Out       = out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_left_rotator_seq.sv
// Directed, table-driven bench for left_rotator_seq plus hand-written multi-cycle sequences
// (backpressure, in_valid held across DONE->IDLE, reset mid-operation).
module tb_left_rotator_seq;

  logic clk;
  logic rst_n;

  left_rotator_seq_if #(.WIDTH(16), .CNT_W(4)) bus ();

  left_rotator_seq #(
    .WIDTH(16),
    .CNT_W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic        op;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] din, input logic [3:0] cnt, input logic op);
    bus.In  = din;
    bus.Cnt = cnt;
`ifdef LEFT_ROTATOR_SHIFT_OP_EN
    bus.Op  = op;
`else
    if (op) $display("note: op=1 vector in a rotate-only build");
`endif
  endtask

  // Count cycles from the capture edge until out_valid, bounded.
  task automatic wait_result(input string name, input logic [15:0] exp);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, lat, 4);
    check({name, " out"}, bus.Out, exp);
  endtask

  task automatic run_op(input string name, input logic [15:0] din, input logic [3:0] cnt,
                        input logic op, input logic [15:0] exp, input bit ack);
    drive(din, cnt, op);
    bus.in_valid = 1'b1;
    check({name, " in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({name, " busy"}, bus.busy, 1);
    check({name, " in_ready low"}, bus.in_ready, 0);
    wait_result(name, exp);
    if (ack) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({name, " out_valid drop"}, bus.out_valid, 0);
      check({name, " out kept"}, bus.Out, exp);
      check({name, " back idle"}, bus.in_ready, 1);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(16'h0, 4'h0, 1'b0);

    vecs.push_back('{"rol1",    16'h8001, 4'd1,  1'b0, 16'h0003});
    vecs.push_back('{"rol4",    16'h1234, 4'd4,  1'b0, 16'h2341});
    vecs.push_back('{"rol15",   16'h0001, 4'd15, 1'b0, 16'h8000});
    vecs.push_back('{"ror1eq",  16'h8000, 4'd15, 1'b0, 16'h4000});
    vecs.push_back('{"rol0",    16'hABCD, 4'd0,  1'b0, 16'hABCD});
    vecs.push_back('{"rol3",    16'h5A5A, 4'd3,  1'b0, 16'hD2D2});
`ifdef LEFT_ROTATOR_SHIFT_OP_EN
    vecs.push_back('{"sll1",    16'h8001, 4'd1,  1'b1, 16'h0002});
    vecs.push_back('{"rol1op0", 16'h8001, 4'd1,  1'b0, 16'h0003});
    vecs.push_back('{"sll15",   16'hFFFF, 4'd15, 1'b1, 16'h8000});
    vecs.push_back('{"sll5",    16'h0F0F, 4'd5,  1'b1, 16'hE1E0});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out", bus.Out, 16'h0000);
    check("rst busy", bus.busy, 0);

    // Table: out_ready held high throughout, so it is also high outside DONE.
    bus.out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].name, vecs[i].din, vecs[i].cnt, vecs[i].op, vecs[i].exp, 1'b1);
    end

    // Backpressure; a second operand is offered while the result waits.
    bus.out_ready = 1'b0;
    run_op("bp", 16'h00F0, 4'd8, 1'b0, 16'hF000, 1'b0);
    drive(16'h1111, 4'd1, 1'b0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp out_valid held", bus.out_valid, 1);
      check("bp out held", bus.Out, 16'hF000);
      check("bp in_ready low", bus.in_ready, 0);
    end
    // in_valid stays high across DONE->IDLE and is captured on the first IDLE edge.
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp idle out_valid", bus.out_valid, 0);
    check("bp idle in_ready", bus.in_ready, 1);
    check("bp idle out", bus.Out, 16'hF000);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("held capture in_ready", bus.in_ready, 0);
    check("held capture busy", bus.busy, 1);
    wait_result("held", 16'h2222);
    @(posedge clk);
    #1;
    check("held ack", bus.out_valid, 0);

    // Reset after two shift stages aborts immediately.
    drive(16'hFFFF, 4'd5, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", bus.out_valid, 0);
    check("abort out", bus.Out, 16'h0000);
    check("abort in_ready", bus.in_ready, 1);
    check("abort busy", bus.busy, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_rst", 16'h0F00, 4'd4, 1'b0, 16'hF000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
